regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-port integer register file for the pipelined NPC core. It succeeds the single-write/two-read file. It has configurable XLEN, register count and read-port count, two write-back ports with defined priority, and a per-register busy scoreboard for issue-stage hazard detection. A flush input squashes pending producers. Sits between decode/issue (reads, issue marks) and write-back (writes).

Parameters:
XLEN, 64, data width of each register in bits
NREG, 32, number of architectural registers (power of 2, >= 2); register 0 hardwired to zero
AW, 5, register address width; must equal log2(NREG)
NRP, 2, number of read ports (1..4)

Ports:
clk  input  1  core clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
rd_addr  input  NRP*AW  read addresses, port k at bits [k*AW +: AW]
rd_data  output  NRP*XLEN  read data, port k at bits [k*XLEN +: XLEN]
rd_ready  output  NRP  1 = operand on port k is valid (no pending producer)
we0  input  1  write-back port 0 enable
waddr0  input  AW  write-back port 0 address
wdata0  input  XLEN  write-back port 0 data
we1  input  1  write-back port 1 enable (priority port)
waddr1  input  AW  write-back port 1 address
wdata1  input  XLEN  write-back port 1 data
iss_en  input  1  issue of an instruction that will write iss_rd
iss_rd  input  AW  destination of issuing instruction
flush  input  1  synchronous squash of all busy bits
busy_vec  output  NREG  current scoreboard state, bit i = register i pending

Behaviour:
- Reset (rst=0, asynchronous): all registers = 0, all busy bits = 0. While rst is low: rd_data = 0, rd_ready = all 1s, busy_vec = 0. Reset mid-operation discards all pending writes and marks immediately.
- Register 0:
  - Reads always return 0 with rd_ready=1.
  - Writes to address 0 are ignored.
  - Issue marks to address 0 are ignored.
  - busy_vec[0] is always 0.
- Writes: registered on the clk rising edge.
  - we0/we1 to different addresses: both commit.
  - Same nonzero address: port 1 data commits and port 0 is dropped.
- Reads: combinational from array contents (without REGFILE_BYPASS_EN). A write is visible on rd_data the cycle after its edge.
- Scoreboard, per register i (i != 0), evaluated at each edge:
  - set: iss_en && iss_rd==i
  - clr: (we0 && waddr0==i) || (we1 && waddr1==i)
  - flush=1: all busy bits go to 0, and the issue mark in the same cycle is also discarded. Writes in that cycle still commit to the array.
  - else if set: busy=1. Set wins over a simultaneous clr, because the new producer supersedes the retiring one.
  - else if clr: busy=0.
  - else: hold.
- rd_ready[k] = !busy[rd_addr_k] (without REGFILE_BYPASS_EN).
- Addresses are AW bits wide and all map to valid entries. NREG must equal 2^AW, so there is no out-of-range case.
- Latency: write to read 1 cycle; issue mark to busy 1 cycle; write-back clear to ready 1 cycle.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: same-cycle write-to-read forwarding. For read port k with rd_addr_k != 0:
  - If we1 && waddr1==rd_addr_k: rd_data = wdata1 and rd_ready = 1.
  - Else if we0 && waddr0==rd_addr_k: rd_data = wdata0 and rd_ready = 1.
  - Else: array and scoreboard values as above.
- Undefined: no forwarding; read data and readiness come from registered state only.
- Register 0 behaviour is identical in both builds.

Test Plan:
- Reset: hold rst=0 for 3 cycles, release -> all 32 reads return 0, rd_ready=all 1s, busy_vec=0. Assert rst=0 mid-stream after writing x5=0x1234 -> x5 reads 0 immediately, without waiting for a clock edge.
- Write/read: we0 x3=0xDEADBEEF_00000001 -> next cycle rd_addr0=3 returns it. we0 x0=0xFF -> x0 still reads 0.
- Write collision: we0 and we1 to x7 with 0xAAAA / 0x5555 in the same cycle -> x7 reads 0x5555. Different addresses x8/x9 -> both commit.
- Scoreboard:
  - iss_en x10 -> busy_vec[10]=1 next cycle, rd_ready=0 for reads of x10.
  - we1 x10=0x42 -> ready and data 0x42 the cycle after.
  - Issue x11 and write x11 in the same cycle -> busy_vec[11] stays 1.
- Flush: mark x12, x13 busy, then pulse flush with iss_en x14 and we0 x15=0x99 -> busy_vec=0 next cycle, and x15 reads 0x99.
- Bypass (REGFILE_BYPASS_EN build only): x20 busy, we0 x20=0x77 with rd_addr1=20 in the same cycle -> rd_data1=0x77, rd_ready[1]=1 that cycle. In a non-bypass build the same stimulus -> old value and rd_ready[1]=0.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp -- multi-port integer register file with issue scoreboard.
//
// Two write-back ports (port 1 has priority on an address collision), NRP
// combinational read ports, and a per-register busy bit that issue sets and
// write-back clears. x0 is hardwired to zero, never busy, always ready.
//
// Optional build macro: REGFILE_BYPASS_EN -- forwards same-cycle write-back
// data to the read ports and reports the operand ready.
//
// Ports:
//   clk, rst          core clock; asynchronous active-low reset
//   rd_addr/rd_data   NRP packed read ports (port k at [k*AW], [k*XLEN])
//   rd_ready          per-port operand valid (no pending producer)
//   we0/waddr0/wdata0 write-back port 0
//   we1/waddr1/wdata1 write-back port 1 (wins on same address)
//   iss_en/iss_rd     issue mark of a pending producer
//   flush             squash all busy bits (writes still commit)
//   busy_vec          scoreboard state, bit i = register i pending

// Per read-port lookup: array/scoreboard read, optional forwarding.
module regfile_mp_rport #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic                      rst,
    input  logic [AW-1:0]             addr,
    input  logic [NREG-1:0][XLEN-1:0] regs,
    input  logic [NREG-1:0]           busy,
`ifdef REGFILE_BYPASS_EN
    input  logic                      we0,
    input  logic [AW-1:0]             waddr0,
    input  logic [XLEN-1:0]           wdata0,
    input  logic                      we1,
    input  logic [AW-1:0]             waddr1,
    input  logic [XLEN-1:0]           wdata1,
`endif
    output logic [XLEN-1:0]           data,
    output logic                      ready
);
    always_comb begin
        // regs[0] is held at zero and busy[0] is never set, so x0 needs no
        // special case on the array path.
        data  = regs[addr];
        ready = !busy[addr];
`ifdef REGFILE_BYPASS_EN
        if (addr != '0) begin
            if (we1 && waddr1 == addr) begin
                data  = wdata1;
                ready = 1'b1;
            end else if (we0 && waddr0 == addr) begin
                data  = wdata0;
                ready = 1'b1;
            end
        end
`endif
        // Forwarded write data must not leak out while reset is held.
        if (!rst) begin
            data  = '0;
            ready = 1'b1;
        end
    end
endmodule

module regfile_mp #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int NRP  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRP*AW-1:0]   rd_addr,
    output logic [NRP*XLEN-1:0] rd_data,
    output logic [NRP-1:0]      rd_ready,
    input  logic                we0,
    input  logic [AW-1:0]       waddr0,
    input  logic [XLEN-1:0]     wdata0,
    input  logic                we1,
    input  logic [AW-1:0]       waddr1,
    input  logic [XLEN-1:0]     wdata1,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_rd,
    input  logic                flush,
    output logic [NREG-1:0]     busy_vec
);
    logic [NREG-1:0][XLEN-1:0] regs;
    logic [NREG-1:0]           busy;

    // Array: entry 0 only ever sees the reset value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (we1 && waddr1 == AW'(i))
                    regs[i] <= wdata1;
                else if (we0 && waddr0 == AW'(i))
                    regs[i] <= wdata0;
            end
        end
    end

    // Scoreboard: flush > set > clr > hold. Set beats clr because the newly
    // issued producer supersedes the one retiring this cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else if (flush) begin
            busy <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (iss_en && iss_rd == AW'(i))
                    busy[i] <= 1'b1;
                else if ((we0 && waddr0 == AW'(i)) || (we1 && waddr1 == AW'(i)))
                    busy[i] <= 1'b0;
            end
        end
    end

    assign busy_vec = busy;

    for (genvar k = 0; k < NRP; k++) begin : g_rp
        regfile_mp_rport #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) u_rport (
            .rst    (rst),
            .addr   (rd_addr[k*AW +: AW]),
            .regs   (regs),
            .busy   (busy),
`ifdef REGFILE_BYPASS_EN
            .we0    (we0),
            .waddr0 (waddr0),
            .wdata0 (wdata0),
            .we1    (we1),
            .waddr1 (waddr1),
            .wdata1 (wdata1),
`endif
            .data   (rd_data[k*XLEN +: XLEN]),
            .ready  (rd_ready[k])
        );
    end
endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;
    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int NRP  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NRP*AW-1:0]   rd_addr;
    logic [NRP*XLEN-1:0] rd_data;
    logic [NRP-1:0]      rd_ready;
    logic                we0, we1, iss_en, flush;
    logic [AW-1:0]       waddr0, waddr1, iss_rd;
    logic [XLEN-1:0]     wdata0, wdata1;
    logic [NREG-1:0]     busy_vec;

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NRP(NRP)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_ready(rd_ready), .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1), .iss_en(iss_en),
        .iss_rd(iss_rd), .flush(flush), .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    // kind: 0 = rd_data of port, 1 = rd_ready vector, 2 = busy_vec
    typedef struct {
        int          at;
        int          kind;
        int          port;
        logic [63:0] val;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every negedge, compare all expectations scheduled for this cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].at <= cyc) begin
            exp_t e;
            logic [63:0] act;
            e = q.pop_front();
            case (e.kind)
                0:       act = rd_data[e.port*XLEN +: XLEN];
                1:       act = 64'(rd_ready);
                default: act = 64'(busy_vec);
            endcase
            n_cmp++;
            if (e.at != cyc) begin
                n_bad++;
                $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", e.name, e.at, cyc);
            end else if (act !== e.val) begin
                n_bad++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val);
            end
        end
    end

    task automatic expect_v(input int kind, input int port, input logic [63:0] val, input string name);
        exp_t e;
        e.at = cyc; e.kind = kind; e.port = port; e.val = val; e.name = name;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; iss_en = 0; flush = 0;
        waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0; iss_rd = '0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    initial begin
        rst = 1'b0;
        idle();
        set_rd(5'd3, 5'd9);
        step();
        expect_v(0, 0, 64'h0, "reset_data0");
        expect_v(1, 0, 64'h3, "reset_ready");
        expect_v(2, 0, 64'h0, "reset_busy");
        step();
        step();
        rst = 1'b1;

        // All registers read zero and ready after reset.
        for (int a = 0; a < NREG; a++) begin
            set_rd(AW'(a), AW'(NREG - 1 - a));
            expect_v(0, 0, 64'h0, "post_reset_data0");
            expect_v(0, 1, 64'h0, "post_reset_data1");
            expect_v(1, 0, 64'h3, "post_reset_ready");
            step();
        end
        expect_v(2, 0, 64'h0, "post_reset_busy");

        // Plain write, visible next cycle.
        we0 = 1; waddr0 = 5'd3; wdata0 = 64'hDEADBEEF_00000001;
        step();
        idle();
        set_rd(5'd3, 5'd0);
        expect_v(0, 0, 64'hDEADBEEF_00000001, "wr_x3");
        expect_v(0, 1, 64'h0, "rd_x0_p1");

        // Writes and issue marks to x0 are ignored.
        we0 = 1; waddr0 = 5'd0; wdata0 = 64'hFF; iss_en = 1; iss_rd = 5'd0;
        step();
        idle();
        set_rd(5'd0, 5'd3);
        expect_v(0, 0, 64'h0, "wr_x0_ignored");
        expect_v(0, 1, 64'hDEADBEEF_00000001, "x3_hold");
        expect_v(1, 0, 64'h3, "x0_ready");
        expect_v(2, 0, 64'h0, "x0_never_busy");

        // Same-address collision: port 1 wins.
        we0 = 1; waddr0 = 5'd7; wdata0 = 64'hAAAA;
        we1 = 1; waddr1 = 5'd7; wdata1 = 64'h5555;
        step();
        idle();
        set_rd(5'd3, 5'd7);
        expect_v(0, 1, 64'h5555, "collision_x7");

        // Different addresses: both commit.
        we0 = 1; waddr0 = 5'd8; wdata0 = 64'h88;
        we1 = 1; waddr1 = 5'd9; wdata1 = 64'h99;
        step();
        idle();
        set_rd(5'd8, 5'd9);
        expect_v(0, 0, 64'h88, "dual_x8");
        expect_v(0, 1, 64'h99, "dual_x9");

        // Issue mark -> busy next cycle.
        iss_en = 1; iss_rd = 5'd10;
        step();
        idle();
        set_rd(5'd10, 5'd9);
        expect_v(2, 0, 64'h400, "iss_x10_busy");
        expect_v(1, 0, 64'h2, "iss_x10_not_ready");
        // Write-back clears it.
        we1 = 1; waddr1 = 5'd10; wdata1 = 64'h42;
        step();
        idle();
        expect_v(2, 0, 64'h0, "wb_x10_clear");
        expect_v(1, 0, 64'h3, "wb_x10_ready");
        expect_v(0, 0, 64'h42, "wb_x10_data");

        // Issue and write-back to same register: set wins.
        iss_en = 1; iss_rd = 5'd11; we0 = 1; waddr0 = 5'd11; wdata0 = 64'h11;
        step();
        idle();
        set_rd(5'd11, 5'd0);
        expect_v(2, 0, 64'h800, "set_beats_clr");
        expect_v(0, 0, 64'h11, "set_clr_data");
        expect_v(1, 0, 64'h2, "set_clr_ready");

        // Flush: drops all busy bits and the same-cycle issue, keeps the write.
        iss_en = 1; iss_rd = 5'd12;
        step();
        iss_rd = 5'd13;
        step();
        idle();
        expect_v(2, 0, 64'h3800, "pre_flush_busy");
        flush = 1; iss_en = 1; iss_rd = 5'd14; we0 = 1; waddr0 = 5'd15; wdata0 = 64'h99;
        step();
        idle();
        set_rd(5'd15, 5'd14);
        expect_v(2, 0, 64'h0, "flush_busy");
        expect_v(0, 0, 64'h99, "flush_write");
        expect_v(1, 0, 64'h3, "flush_ready");

        // Same-cycle write to a busy register being read.
        iss_en = 1; iss_rd = 5'd20;
        step();
        idle();
        we0 = 1; waddr0 = 5'd20; wdata0 = 64'h77;
        set_rd(5'd0, 5'd20);
`ifdef REGFILE_BYPASS_EN
        expect_v(0, 1, 64'h77, "bypass_data");
        expect_v(1, 0, 64'h3, "bypass_ready");
`else
        expect_v(0, 1, 64'h0, "nobypass_data");
        expect_v(1, 0, 64'h1, "nobypass_ready");
`endif
        step();
        idle();
        expect_v(0, 1, 64'h77, "after_bypass_data");
        expect_v(1, 0, 64'h3, "after_bypass_ready");
        expect_v(2, 0, 64'h0, "after_bypass_busy");

        // Mid-stream asynchronous reset.
        we0 = 1; waddr0 = 5'd5; wdata0 = 64'h1234; iss_en = 1; iss_rd = 5'd6;
        step();
        idle();
        set_rd(5'd5, 5'd6);
        expect_v(0, 0, 64'h1234, "pre_rst_x5");
        expect_v(2, 0, 64'h40, "pre_rst_busy");
        step();
        rst = 1'b0;
        expect_v(0, 0, 64'h0, "async_rst_x5");
        expect_v(1, 0, 64'h3, "async_rst_ready");
        expect_v(2, 0, 64'h0, "async_rst_busy");
        step();
        rst = 1'b1;
        expect_v(0, 0, 64'h0, "after_rst_x5");
        step();
        step();

        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations never sampled", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
